// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dcache_pkg
// Description : Shared types, field widths and address-split helpers for the
//               direct-mapped write-back data-cache controller.
// Revision    : 1.0 - initial release
// ============================================================================
package dcache_pkg;

    localparam int OFFSET_W = 5;
    localparam int INDEX_W  = 5;
    localparam int TAG_W    = 22;
    localparam int LINE_W   = 256;
    localparam int WORDS    = 8;
    localparam int WORD_W   = 32;
    localparam int WSEL_W   = 3;
    localparam int LADDR_W  = 9;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COMPARE   = 2'd1,
        WRITEBACK = 2'd2,
        ALLOCATE  = 2'd3
    } state_t;

    // Line index inside the cache
    function automatic logic [INDEX_W-1:0] addr_index(input logic [31:0] addr);
        return addr[9:5];
    endfunction

    // Full tag; compared over all bits even though memory decodes fewer
    function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] addr);
        return addr[31:10];
    endfunction

    // Word select inside a line
    function automatic logic [WSEL_W-1:0] addr_word(input logic [31:0] addr);
        return addr[4:2];
    endfunction

    // Data_Memory line address
    function automatic logic [LADDR_W-1:0] addr_line(input logic [31:0] addr);
        return addr[13:5];
    endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_data_array.sv
`default_nettype none
// ============================================================================
// Module      : dcache_data_array
// Description : Line storage for the data cache. Synchronous write (full line
//               for refill, per-word enables for store hits), asynchronous read.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_data_array #(
    parameter int LINES  = 32,
    parameter int LINE_W = 256,
    parameter int IDX_W  = 5,
    parameter int WORDS  = 8
) (
    input  logic                    clk,
    input  logic [IDX_W-1:0]        i_idx,
    input  logic                    i_line_we,
    input  logic [LINE_W-1:0]       i_line_wdata,
    input  logic [WORDS-1:0]        i_word_we,
    input  logic [LINE_W/WORDS-1:0] i_word_wdata,
    output logic [LINE_W-1:0]       o_rd_line
);

    localparam int c_WORD_W = LINE_W / WORDS;

    logic [LINE_W-1:0] r_mem [LINES];

    // Refill takes priority over word writes; the controller never issues both
    always_ff @(posedge clk) begin
        if (i_line_we) begin
            r_mem[i_idx] <= i_line_wdata;
        end else begin
            for (int w = 0; w < WORDS; w++) begin
                if (i_word_we[w]) begin
                    r_mem[i_idx][w*c_WORD_W +: c_WORD_W] <= i_word_wdata;
                end
            end
        end
    end

    assign o_rd_line = r_mem[i_idx];

endmodule
`default_nettype wire

// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dcache_ctrl
// Description : Direct-mapped, write-back, write-allocate data-cache controller
//               between the CPU memory stage and a line-wide Data_Memory.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_ctrl #(
    parameter int LINES  = 32,
    parameter int LINE_W = 256,
    parameter int MEM_AW = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req_valid,
    input  logic              cpu_req_rw,
    input  logic [31:0]       cpu_req_addr,
    input  logic [31:0]       cpu_req_wdata,
    output logic              cpu_res_ready,
    output logic [31:0]       cpu_res_rdata,
    output logic              cpu_stall,
    output logic              mem_req_valid,
    output logic              mem_req_rw,
    output logic [MEM_AW-1:0] mem_req_addr,
    output logic [LINE_W-1:0] mem_req_wdata,
    input  logic              mem_res_ready,
    input  logic [LINE_W-1:0] mem_res_rdata
);
    import dcache_pkg::*;

    state_t              r_state, w_state_nxt;
    logic [31:0]         r_addr, r_wdata;
    logic                r_rw;
    logic [LINES-1:0]    r_valid, r_dirty;
    logic [TAG_W-1:0]    r_tag_mem [LINES];

    logic [INDEX_W-1:0]  w_idx;
    logic [TAG_W-1:0]    w_tag;
    logic [WSEL_W-1:0]   w_wsel;
    logic [LINE_W-1:0]   w_rd_line;
    logic [TAG_W-1:0]    w_victim_tag;
    logic                w_hit;
    logic                w_accept, w_line_we, w_set_dirty, w_clr_dirty;
    logic [WORDS-1:0]    w_word_we;
    logic                w_res_ready_nxt, w_mem_valid_nxt, w_mem_rw_nxt;
    logic [31:0]         w_res_rdata_nxt;
    logic [MEM_AW-1:0]   w_mem_addr_nxt;
    logic [LINE_W-1:0]   w_mem_wdata_nxt;
    logic                w_unused_addr;

    assign w_unused_addr = ^cpu_req_addr[1:0];

    assign w_idx        = addr_index(r_addr);
    assign w_tag        = addr_tag(r_addr);
    assign w_wsel       = addr_word(r_addr);
    assign w_victim_tag = r_tag_mem[w_idx];
    assign w_hit        = r_valid[w_idx] && (w_victim_tag == w_tag);

    dcache_data_array #(
        .LINES  (LINES),
        .LINE_W (LINE_W),
        .IDX_W  (INDEX_W),
        .WORDS  (WORDS)
    ) u_data (
        .clk          (clk),
        .i_idx        (w_idx),
        .i_line_we    (w_line_we),
        .i_line_wdata (mem_res_rdata),
        .i_word_we    (w_word_we),
        .i_word_wdata (r_wdata),
        .o_rd_line    (w_rd_line)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    // Next state, array write strobes and next values of the registered outputs
    always_comb begin
        w_state_nxt     = r_state;
        cpu_stall       = 1'b1;
        w_accept        = 1'b0;
        w_line_we       = 1'b0;
        w_word_we       = '0;
        w_set_dirty     = 1'b0;
        w_clr_dirty     = 1'b0;
        w_res_ready_nxt = 1'b0;
        w_res_rdata_nxt = cpu_res_rdata;
        w_mem_valid_nxt = mem_req_valid;
        w_mem_rw_nxt    = mem_req_rw;
        w_mem_addr_nxt  = mem_req_addr;
        w_mem_wdata_nxt = mem_req_wdata;
        case (r_state)
            IDLE: begin
                cpu_stall = 1'b0;
                // The CPU still holds the finished request during the response pulse
                if (cpu_req_valid && !cpu_res_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = COMPARE;
                end
            end
            COMPARE: begin
                if (w_hit) begin
                    cpu_stall       = 1'b0;
                    w_res_ready_nxt = 1'b1;
                    if (r_rw) begin
                        w_word_we[w_wsel] = 1'b1;
                        w_set_dirty       = 1'b1;
                    end else begin
                        w_res_rdata_nxt = w_rd_line[w_wsel*WORD_W +: WORD_W];
                    end
                    w_state_nxt = IDLE;
                end else if (r_dirty[w_idx]) begin
                    w_mem_valid_nxt = 1'b1;
                    w_mem_rw_nxt    = 1'b1;
                    w_mem_addr_nxt  = MEM_AW'({w_victim_tag[3:0], w_idx});
                    w_mem_wdata_nxt = w_rd_line;
                    w_state_nxt     = WRITEBACK;
                end else begin
                    w_mem_valid_nxt = 1'b1;
                    w_mem_rw_nxt    = 1'b0;
                    w_mem_addr_nxt  = MEM_AW'(addr_line(r_addr));
                    w_state_nxt     = ALLOCATE;
                end
            end
            WRITEBACK: begin
                if (mem_req_valid && mem_res_ready) begin
                    w_clr_dirty     = 1'b1;
                    w_mem_valid_nxt = 1'b0;
                    w_state_nxt     = ALLOCATE;
                end
            end
            ALLOCATE: begin
                // After a writeback the request line idles one cycle before the refill read
                if (!mem_req_valid) begin
                    w_mem_valid_nxt = 1'b1;
                    w_mem_rw_nxt    = 1'b0;
                    w_mem_addr_nxt  = MEM_AW'(addr_line(r_addr));
                end else if (mem_res_ready) begin
                    w_line_we       = 1'b1;
                    w_clr_dirty     = 1'b1;
                    w_mem_valid_nxt = 1'b0;
                    w_state_nxt     = COMPARE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Registered CPU and memory-side outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_res_ready <= 1'b0;
            cpu_res_rdata <= '0;
            mem_req_valid <= 1'b0;
            mem_req_rw    <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
        end else begin
            cpu_res_ready <= w_res_ready_nxt;
            cpu_res_rdata <= w_res_rdata_nxt;
            mem_req_valid <= w_mem_valid_nxt;
            mem_req_rw    <= w_mem_rw_nxt;
            mem_req_addr  <= w_mem_addr_nxt;
            mem_req_wdata <= w_mem_wdata_nxt;
        end
    end

    // Latch the accepted CPU request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr  <= '0;
            r_rw    <= 1'b0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_addr  <= {cpu_req_addr[31:2], 2'b00};
            r_rw    <= cpu_req_rw;
            r_wdata <= cpu_req_wdata;
        end
    end

    // Valid and dirty bits; set wins over clear only on store hits, which never clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else begin
            if (w_line_we)   r_valid[w_idx] <= 1'b1;
            if (w_clr_dirty) r_dirty[w_idx] <= 1'b0;
            if (w_set_dirty) r_dirty[w_idx] <= 1'b1;
        end
    end

    // Tag storage, written with the refill
    always_ff @(posedge clk) begin
        if (w_line_we) r_tag_mem[w_idx] <= w_tag;
    end

endmodule
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcache_ctrl
// Description : Scoreboard bench for dcache_ctrl with a Data_Memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         cpu_req_valid = 1'b0;
    logic         cpu_req_rw = 1'b0;
    logic [31:0]  cpu_req_addr = '0;
    logic [31:0]  cpu_req_wdata = '0;
    logic         cpu_res_ready;
    logic [31:0]  cpu_res_rdata;
    logic         cpu_stall;
    logic         mem_req_valid;
    logic         mem_req_rw;
    logic [8:0]   mem_req_addr;
    logic [255:0] mem_req_wdata;
    logic         mem_res_ready = 1'b0;
    logic [255:0] mem_res_rdata = '0;

    dcache_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .cpu_req_valid (cpu_req_valid),
        .cpu_req_rw    (cpu_req_rw),
        .cpu_req_addr  (cpu_req_addr),
        .cpu_req_wdata (cpu_req_wdata),
        .cpu_res_ready (cpu_res_ready),
        .cpu_res_rdata (cpu_res_rdata),
        .cpu_stall     (cpu_stall),
        .mem_req_valid (mem_req_valid),
        .mem_req_rw    (mem_req_rw),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wdata (mem_req_wdata),
        .mem_res_ready (mem_res_ready),
        .mem_res_rdata (mem_res_rdata)
    );

    always #5 clk = ~clk;

    typedef struct { bit is_load; logic [31:0] data; } res_t;
    typedef struct { bit rw; logic [8:0] addr; logic [255:0] wdata; } mreq_t;

    res_t   exp_res[$];
    mreq_t  exp_mem[$];
    logic [255:0] mem_array [512];
    int     mem_delay = 0;
    int     n_checks = 0;
    int     n_fail = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] mkline(input logic [31:0] base);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = base + 32'(w);
        return l;
    endfunction

    // CPU response monitor: pops the scoreboard whenever a response pulse appears
    initial begin
        res_t r;
        forever begin
            @(negedge clk);
            if (rst && cpu_res_ready) begin
                if (exp_res.size() == 0) begin
                    check("unexpected_cpu_res", 1, 0);
                end else begin
                    r = exp_res.pop_front();
                    if (r.is_load) check("load_rdata", cpu_res_rdata, r.data);
                end
            end
        end
    end

    // Data_Memory model; also checks each request against the scoreboard and its stability
    initial begin
        mreq_t e;
        bit    c_rw;
        logic [8:0]   c_addr;
        logic [255:0] c_wdata;
        bit    aborted;
        forever begin
            @(negedge clk);
            mem_res_ready = 1'b0;
            if (rst && mem_req_valid) begin
                c_rw = mem_req_rw; c_addr = mem_req_addr; c_wdata = mem_req_wdata;
                if (exp_mem.size() == 0) begin
                    check("unexpected_mem_req", 1, 0);
                end else begin
                    e = exp_mem.pop_front();
                    check("mem_rw", c_rw, e.rw);
                    check("mem_addr", c_addr, e.addr);
                    if (e.rw) check("mem_wdata", c_wdata, e.wdata);
                end
                aborted = 1'b0;
                for (int k = 0; k < mem_delay; k++) begin
                    @(negedge clk);
                    if (!rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    check("hold_valid", mem_req_valid, 1);
                    check("hold_rw", mem_req_rw, c_rw);
                    check("hold_addr", mem_req_addr, c_addr);
                    check("hold_wdata", mem_req_wdata, c_wdata);
                    check("no_early_res", cpu_res_ready, 0);
                end
                if (!aborted) begin
                    if (c_rw) mem_array[c_addr] = c_wdata;
                    else      mem_res_rdata = mem_array[c_addr];
                    mem_res_ready = 1'b1;
                end
            end
        end
    end

    // One CPU access, started and ended on a falling edge
    task automatic cpu_access(input bit rw, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input bit is_hit, input int exp_cycles);
        int n = 0;
        int high = 0;
        bit done = 1'b0;
        exp_res.push_back('{is_load: !rw, data: exp_rdata});
        cpu_req_valid = 1'b1; cpu_req_rw = rw; cpu_req_addr = addr; cpu_req_wdata = wdata;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
            if (cpu_stall) high++;
            if (cpu_res_ready) done = 1'b1;
        end
        cpu_req_valid = 1'b0;
        check("res_seen", done, 1);
        check("latency", n, exp_cycles);
        check("stall_cycles", high, is_hit ? 0 : exp_cycles - 2);
        @(negedge clk);
        check("single_pulse", cpu_res_ready, 0);
    endtask

    initial begin
        logic [255:0] l;
        int t;
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] l;
        int t;
        for (int i = 0; i < 512; i++) mem_array[i] = '0;
        mem_array[0]  = mkline(32'h100);
        mem_array[1]  = mkline(32'd10);
        mem_array[2]  = mkline(32'h400);
        mem_array[32] = mkline(32'h300);
        mem_array[33] = mkline(32'h200);

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_res_ready", cpu_res_ready, 0);
        check("rst_res_rdata", cpu_res_rdata, 0);
        check("rst_stall", cpu_stall, 0);
        check("rst_mem_valid", mem_req_valid, 0);
        check("rst_mem_addr", mem_req_addr, 0);
        rst = 1'b1;

        // Clean miss, then hits in the same line
        exp_mem.push_back('{rw: 1'b0, addr: 9'd1, wdata: '0});
        cpu_access(1'b0, 32'h24, 32'h0, 32'd11, 1'b0, 4);
        cpu_access(1'b0, 32'h28, 32'h0, 32'd12, 1'b1, 2);
        cpu_access(1'b1, 32'h2C, 32'hDEADBEEF, 32'h0, 1'b1, 2);

        // Dirty miss with slow memory: writeback of line 1 then refill of line 33
        l = mkline(32'd10);
        l[127:96] = 32'hDEADBEEF;
        mem_delay = 5;
        exp_mem.push_back('{rw: 1'b1, addr: 9'd1, wdata: l});
        exp_mem.push_back('{rw: 1'b0, addr: 9'd33, wdata: '0});
        cpu_access(1'b0, 32'h42C, 32'h0, 32'h203, 1'b0, 16);
        mem_delay = 0;

        // Line 33 came in clean: going back to line 1 is a read only
        exp_mem.push_back('{rw: 1'b0, addr: 9'd1, wdata: '0});
        cpu_access(1'b0, 32'h2C, 32'h0, 32'hDEADBEEF, 1'b0, 4);

        // Dirty the line, then reset in the middle of its writeback
        cpu_access(1'b1, 32'h24, 32'h12345678, 32'h0, 1'b1, 2);
        l[63:32] = 32'h12345678;
        mem_delay = 6;
        exp_mem.push_back('{rw: 1'b1, addr: 9'd1, wdata: l});
        cpu_req_valid = 1'b1; cpu_req_rw = 1'b0; cpu_req_addr = 32'h424;
        t = 0;
        while (!mem_req_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("wb_started", mem_req_valid && mem_req_rw, 1);
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_rst_mem_valid", mem_req_valid, 0);
        check("async_rst_mem_rw", mem_req_rw, 0);
        check("async_rst_stall", cpu_stall, 0);
        check("async_rst_res_ready", cpu_res_ready, 0);
        cpu_req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        mem_delay = 0;

        // Valid bits were cleared: line 1 refills without a writeback, memory not updated
        exp_mem.push_back('{rw: 1'b0, addr: 9'd1, wdata: '0});
        cpu_access(1'b0, 32'h2C, 32'h0, 32'hDEADBEEF, 1'b0, 4);

        // Index 0: fill with tag 1, then a clean conflict miss with tag 0
        mem_delay = 2;
        exp_mem.push_back('{rw: 1'b0, addr: 9'd32, wdata: '0});
        cpu_access(1'b0, 32'h400, 32'h0, 32'h300, 1'b0, 6);
        mem_delay = 0;
        exp_mem.push_back('{rw: 1'b0, addr: 9'd0, wdata: '0});
        cpu_access(1'b0, 32'h0, 32'h0, 32'h100, 1'b0, 4);

        // Store miss allocates, then the merged line is read back
        exp_mem.push_back('{rw: 1'b0, addr: 9'd2, wdata: '0});
        cpu_access(1'b1, 32'h44, 32'hCAFEF00D, 32'h0, 1'b0, 4);
        cpu_access(1'b0, 32'h44, 32'h0, 32'hCAFEF00D, 1'b1, 2);
        cpu_access(1'b0, 32'h40, 32'h0, 32'h400, 1'b1, 2);

        repeat (3) @(negedge clk);
        check("exp_res_drained", exp_res.size(), 0);
        check("exp_mem_drained", exp_mem.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data-cache controller between the multiMips memory stage and the line-wide Data_Memory (512 lines × 256 bits).
- Accepts single-word CPU loads and stores, resolves hits from its internal arrays and stalls the pipeline on a miss.
- On a miss it writes back a dirty victim line, refills the line from Data_Memory, then replays the access.

Parameters:
- LINES, 32, number of cache lines (index width = 5)
- LINE_W, 256, line width in bits (8 words, offset width = 5)
- MEM_AW, 9, Data_Memory line-address width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- cpu_req_valid  in  1  access request; held until cpu_res_ready
- cpu_req_rw  in  1  1 = store, 0 = load
- cpu_req_addr  in  32  byte address; bits [1:0] ignored
- cpu_req_wdata  in  32  store data
- cpu_res_ready  out  1  one-cycle completion pulse
- cpu_res_rdata  out  32  load data, valid while cpu_res_ready = 1
- cpu_stall  out  1  pipeline freeze
- mem_req_valid  out  1  Data_Memory request
- mem_req_rw  out  1  1 = line write, 0 = line read
- mem_req_addr  out  9  line address
- mem_req_wdata  out  256  victim line
- mem_res_ready  in  1  Data_Memory completion, one-cycle pulse
- mem_res_rdata  in  256  refill line, valid with mem_res_ready

Behaviour:
- Address split:
  - offset = addr[4:0]; word select = addr[4:2]
  - index = addr[9:5]
  - tag = addr[31:10] (22 bits)
  - memory line address = addr[13:5]; victim line address = {stored_tag[3:0], index}
- Storage:
  - tag array 32 × 22 bits; data array 32 × 256 bits; neither is reset
  - valid[31:0] and dirty[31:0] are flops, cleared by reset
- Reset: rst = 0 forces state IDLE and all outputs to 0 immediately (asynchronous). Any in-flight memory request is abandoned.
- FSM states are IDLE, COMPARE, WRITEBACK, ALLOCATE:
  - IDLE: if cpu_req_valid, latch addr/rw/wdata, go to COMPARE. cpu_stall = 0.
  - COMPARE, hit (valid[index] and tag match):
    - load: cpu_res_rdata = selected word
    - store: write the selected word via byte-lane word enable; set dirty[index]
    - pulse cpu_res_ready; go to IDLE
  - COMPARE, miss: go to WRITEBACK if valid & dirty, else to ALLOCATE.
  - WRITEBACK: mem_req_valid = 1, rw = 1, addr = victim line address, wdata = victim line.
    - Outputs held stable until mem_res_ready, then go to ALLOCATE.
    - dirty[index] is cleared on that edge.
  - ALLOCATE: mem_req_valid = 1, rw = 0, addr = latched addr[13:5].
    - On mem_res_ready: write mem_res_rdata into the data array, write the tag, set valid, clear dirty, go to COMPARE (replay is guaranteed to hit).
- cpu_stall = 1 in every state except IDLE and a COMPARE hit.
- Latency:
  - hit: response 1 cycle after acceptance (2 edges)
  - clean miss: 2 + memory latency + 1 cycles
  - dirty miss adds one more memory latency
- mem_req_valid drops in the cycle after mem_res_ready. No back-to-back requests without an intervening state.
- cpu_req_valid is ignored outside IDLE; the CPU holds the request.
- mem_res_ready is ignored outside WRITEBACK and ALLOCATE.
- Tag compare uses all 22 bits even though memory decodes only 9 line bits; aliasing above bit 13 is the software's concern.
- Outputs are registered except cpu_stall, which is combinational from state and hit.

Decomposition:
- Package dcache_pkg holds:
  - the state enum
  - OFFSET_W = 5, INDEX_W = 5, TAG_W = 22, LINE_W = 256, WORDS = 8
  - address-field extraction functions
- Sub-module dcache_data_array: 32 × 256 synchronous-write, asynchronous-read RAM with a full-line write port (refill) and an 8-way word-enable port (store hit).

Test Plan:
- Reset, Data_Memory line 1 preloaded with words 10..17, load 0x24 → mem read at addr 1; cpu_res_rdata = 11 with a single cpu_res_ready pulse; cpu_stall high throughout the miss.
- Immediately load 0x28 → hit, cpu_res_rdata = 12 one cycle after acceptance; mem_req_valid stays 0.
- Store 0xDEADBEEF to 0x2C (hit, dirty), then load 0x42C → write at addr 1 with wdata[127:96] = 0xDEADBEEF, then read at addr 33; dirty[1] = 0 afterwards.
- mem_res_ready delayed 5 cycles → mem_req_valid/rw/addr/wdata held constant for all 5 cycles; no cpu_res_ready until completion.
- Assert rst during WRITEBACK → mem_req_valid = 0 within the same cycle, state IDLE; a later load of 0x2C misses (valid cleared) with no writeback.
- Load 0x0 with index 0 valid, clean, different tag → ALLOCATE only (no rw = 1 request); returned word equals memory line 0 word 0.
